// File: rtl/zicsr_access_ctrl.sv
// Machine-level Zicsr CSR file with a read/modify/write/respond sequencer.
// Trap-side writes take priority over pipeline requests while idle.
module zicsr_access_ctrl #(
  parameter int unsigned     XLEN   = 32,
  parameter logic [XLEN-1:0] HARTID = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic [11:0]     req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic            req_src_zero,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_illegal,
  input  logic            trap_valid,
  output logic            trap_ready,
  input  logic [11:0]     trap_addr,
  input  logic [XLEN-1:0] trap_wdata,
  output logic [XLEN-1:0] mstatus_o,
  output logic [XLEN-1:0] mtvec_o,
  output logic            busy
);

  localparam int unsigned    AW           = 12;
  localparam logic [AW-1:0]  ADDR_USTATUS = 12'h000;
  localparam logic [AW-1:0]  ADDR_MSTATUS = 12'h300;
  localparam logic [AW-1:0]  ADDR_MTVEC   = 12'h305;
  localparam logic [AW-1:0]  ADDR_MHARTID = 12'hF14;
  localparam logic [1:0]     OP_ILL       = 2'b00;
  localparam logic [1:0]     OP_RW        = 2'b01;
  localparam logic [1:0]     OP_RS        = 2'b10;
  localparam logic [XLEN-1:0] MSTATUS_RST = XLEN'(32'h0000_1880);
  localparam logic [XLEN-1:0] MTVEC_MASK  = ~XLEN'(2);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_e;

  state_e          state_q, state_d;
  logic [1:0]      op_q;
  logic [AW-1:0]   addr_q;
  logic [XLEN-1:0] wdata_q;
  logic            src_zero_q;
  logic [XLEN-1:0] old_q;
  logic            ill_q;
  logic [XLEN-1:0] mstatus_q;
  logic [XLEN-1:0] mtvec_q;

  logic            csr_exists, csr_writable;
  logic [XLEN-1:0] csr_rdval, new_val;
  logic            do_write, illegal;
  logic            accept, capture, commit, trap_we;

  // Address decode of the latched request; mtvec is write-only and reads as zero.
  always_comb begin
    csr_exists   = 1'b0;
    csr_writable = 1'b0;
    csr_rdval    = '0;
    unique case (addr_q)
      ADDR_USTATUS: csr_exists = 1'b1;
      ADDR_MSTATUS: begin
        csr_exists   = 1'b1;
        csr_writable = 1'b1;
        csr_rdval    = mstatus_q;
      end
      ADDR_MTVEC: begin
        csr_exists   = 1'b1;
        csr_writable = 1'b1;
      end
      ADDR_MHARTID: begin
        csr_exists = 1'b1;
        csr_rdval  = HARTID;
      end
      default: ;
    endcase
  end

  assign do_write = (op_q == OP_RW) | ~src_zero_q;
  assign illegal  = (op_q == OP_ILL) | ~csr_exists | (do_write & ~csr_writable);

  always_comb begin
    new_val = wdata_q;
    if (op_q == OP_RS)      new_val = old_q | wdata_q;
    else if (op_q != OP_RW) new_val = old_q & ~wdata_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    trap_ready = 1'b0;
    accept     = 1'b0;
    capture    = 1'b0;
    commit     = 1'b0;
    trap_we    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        trap_ready = 1'b1;
        req_ready  = ~trap_valid;
        if (trap_valid) begin
          trap_we = 1'b1;
        end else if (req_valid) begin
          accept  = 1'b1;
          state_d = S_READ;
        end
      end
      S_READ: begin
        capture = 1'b1;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        commit  = do_write & ~ill_q;
        state_d = S_RESP;
      end
      S_RESP: if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Request latch, old-value capture and CSR storage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q       <= OP_ILL;
      addr_q     <= '0;
      wdata_q    <= '0;
      src_zero_q <= 1'b0;
      old_q      <= '0;
      ill_q      <= 1'b0;
      mstatus_q  <= MSTATUS_RST;
      mtvec_q    <= '0;
    end else begin
      if (accept) begin
        op_q       <= req_op;
        addr_q     <= req_addr;
        wdata_q    <= req_wdata;
        src_zero_q <= req_src_zero;
      end
      if (capture) begin
        old_q <= illegal ? '0 : csr_rdval;
        ill_q <= illegal;
      end
      if (trap_we) begin
        if (trap_addr == ADDR_MSTATUS)    mstatus_q <= trap_wdata;
        else if (trap_addr == ADDR_MTVEC) mtvec_q   <= trap_wdata & MTVEC_MASK;
      end
      if (commit) begin
        if (addr_q == ADDR_MSTATUS)    mstatus_q <= new_val;
        else if (addr_q == ADDR_MTVEC) mtvec_q   <= new_val & MTVEC_MASK;
      end
    end
  end

  assign rsp_valid   = (state_q == S_RESP);
  assign rsp_rdata   = old_q;
  assign rsp_illegal = ill_q;
  assign busy        = (state_q != S_IDLE);
  assign mstatus_o   = mstatus_q;
  assign mtvec_o     = mtvec_q;

endmodule
